// File: rtl/coordinate_2dto3d_if.sv
`default_nettype none
// ============================================================================
// Module      : coordinate_2dto3d_if
// Description : Handshake bundle for coordinate_2dto3d. The input side carries
//               a scaled pixel (u, v) and depth z; the output side returns the
//               recovered 3D (x, y) and an error flag for rejected depths.
// Revision    : 1.0 - initial release
// ============================================================================
interface coordinate_2dto3d_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] u;
    logic signed [31:0] v;
    logic signed [15:0] z;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic               err;

    // Producer of tuples / consumer of results
    modport master (
        output in_valid, u, v, z, out_ready,
        input  in_ready, out_valid, x, y, err
    );

    // The conversion block itself
    modport slave (
        input  in_valid, u, v, z, out_ready,
        output in_ready, out_valid, x, y, err
    );
endinterface
`default_nettype wire

// File: rtl/coordinate_2dto3d.sv
`default_nettype none
// ============================================================================
// Module      : coordinate_2dto3d
// Description : Back-projects a scaled pixel (u, v) with depth z into camera
//               space: x = (u - CX*S) * z / (FX*S), y likewise with CY/FY.
//               One multiplier and one 48-cycle restoring divider are shared
//               between the x and y passes; results truncate toward zero and
//               saturate to the signed 32-bit range.
// Revision    : 1.0 - initial release
// ============================================================================
module coordinate_2dto3d #(
    parameter int FX        = 437,
    parameter int FY        = 330,
    parameter int CX        = 242,
    parameter int CY        = 145,
    parameter int PIX_SCALE = 230
) (
    input  logic                 clk,
    input  logic                 rst_n,
    coordinate_2dto3d_if.slave   bus
);

    // Principal-point offsets in scaled pixel units, and the two divisors
    localparam logic signed [32:0] c_cx_off = 33'(CX * PIX_SCALE);
    localparam logic signed [32:0] c_cy_off = 33'(CY * PIX_SCALE);
    localparam logic [31:0]        c_div_x  = 32'(FX * PIX_SCALE);
    localparam logic [31:0]        c_div_y  = 32'(FY * PIX_SCALE);
    localparam logic [5:0]         c_last   = 6'd47;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULX = 3'd1,
        DIVX = 3'd2,
        MULY = 3'd3,
        DIVY = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t             r_state;
    logic signed [31:0] r_u;
    logic signed [31:0] r_v;
    logic [15:0]        r_z;
    logic [31:0]        r_rem;
    logic [47:0]        r_quo;
    logic [5:0]         r_cnt;
    logic               r_neg;
    logic signed [31:0] r_x;
    logic signed [31:0] r_y;
    logic               r_err;
    logic               r_out_valid;

    logic signed [32:0] w_diff_x;
    logic signed [32:0] w_diff_y;
    logic signed [32:0] w_diff_sel;
    logic [32:0]        w_abs_diff;
    logic [47:0]        w_prod;
    logic [31:0]        w_divisor;
    logic [32:0]        w_rem_sh;
    logic               w_ge;
    logic [31:0]        w_rem_next;
    logic [47:0]        w_quo_next;
    logic               w_overflow;
    logic signed [31:0] w_result;

    // Centred pixel coordinates; 33 bits so the subtraction never wraps
    assign w_diff_x   = {r_u[31], r_u} - c_cx_off;
    assign w_diff_y   = {r_v[31], r_v} - c_cy_off;
    assign w_diff_sel = (r_state == MULY) ? w_diff_y : w_diff_x;
    assign w_abs_diff = w_diff_sel[32] ? 33'(-w_diff_sel) : 33'(w_diff_sel);

    // z is known positive here, so the product magnitude is |diff| * z;
    // |diff| < 2^33 and z < 2^15 keep it inside 48 bits
    assign w_prod     = 48'(w_abs_diff) * 48'(r_z);

    // One restoring-division step: shift in the next dividend bit, subtract
    // the divisor when it fits. The quotient register doubles as dividend.
    assign w_divisor  = (r_state == DIVY) ? c_div_y : c_div_x;
    assign w_rem_sh   = {r_rem, r_quo[47]};
    assign w_ge       = (w_rem_sh >= {1'b0, w_divisor});
    assign w_rem_next = w_ge ? 32'(w_rem_sh - {1'b0, w_divisor}) : w_rem_sh[31:0];
    assign w_quo_next = {r_quo[46:0], w_ge};

    // Apply the sign after division; clamp magnitudes beyond 2^31-1.
    // A zero quotient negates to zero, so no -0 special case is needed.
    assign w_overflow = |w_quo_next[47:31];
    assign w_result   = w_overflow ? (r_neg ? 32'sh8000_0000 : 32'sh7FFF_FFFF)
                                   : (r_neg ? -$signed(w_quo_next[31:0])
                                            :  $signed(w_quo_next[31:0]));

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.err       = r_err;

    // Control FSM plus datapath registers: accept, multiply, divide x then y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_u         <= '0;
            r_v         <= '0;
            r_z         <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_u <= bus.u;
                        r_v <= bus.v;
                        r_z <= bus.z;
                        if (bus.z > 16'sd0) begin
                            r_state <= MULX;
                        end else begin
                            r_x         <= '0;
                            r_y         <= '0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                MULX, MULY: begin
                    r_quo   <= w_prod;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_neg   <= w_diff_sel[32];
                    r_state <= (r_state == MULX) ? DIVX : DIVY;
                end
                DIVX, DIVY: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_last) begin
                        if (r_state == DIVX) begin
                            r_x     <= w_result;
                            r_state <= MULY;
                        end else begin
                            r_y         <= w_result;
                            r_err       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coordinate_2dto3d.sv
`default_nettype none
// ============================================================================
// Module      : tb_coordinate_2dto3d
// Description : Self-checking bench for coordinate_2dto3d: directed cases,
//               back-pressure hold, mid-operation reset and random tuples
//               compared against a plain-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coordinate_2dto3d;
    localparam int FX        = 437;
    localparam int FY        = 330;
    localparam int CX        = 242;
    localparam int CY        = 145;
    localparam int PIX_SCALE = 230;
    localparam int LAT_OK    = 98;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    coordinate_2dto3d_if bus();

    coordinate_2dto3d #(
        .FX(FX), .FY(FY), .CX(CX), .CY(CY), .PIX_SCALE(PIX_SCALE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Absolute time limit so a stuck run still ends
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Reference: exact integer arithmetic, SV division truncates toward zero
    function automatic logic [31:0] ref_coord(input longint p, input longint off,
                                              input longint zz, input longint dv);
        longint q;
        q = ((p - off) * zz) / dv;
        if (q > 64'sd2147483647)  q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
        return q[31:0];
    endfunction

    // Present one tuple, wait for the result, check it, optionally hold
    // back-pressure for some cycles, then release it.
    task automatic do_tuple(input string tag, input logic [31:0] uu, input logic [31:0] vv,
                            input logic [15:0] zz, input logic [31:0] ex, input logic [31:0] ey,
                            input logic ee, input int elat, input int hold);
        int lat;
        bus.in_valid = 1'b1;
        bus.u = uu;
        bus.v = vv;
        bus.z = zz;
        check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_x"}, bus.x, ex);
        check({tag, "_y"}, bus.y, ey);
        check({tag, "_err"}, 32'(bus.err), 32'(ee));
        check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.u = $urandom;
            bus.v = $urandom;
            bus.z = 16'($urandom);
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_x"}, bus.x, ex);
            check({tag, "_hold_y"}, bus.y, ey);
            check({tag, "_hold_err"}, 32'(bus.err), 32'(ee));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_release_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ru;
        logic [31:0] rv;
        logic [15:0] rz;
        int          zi;
        logic [31:0] ex;
        logic [31:0] ey;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.u = '0;
        bus.v = '0;
        bus.z = '0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_x", bus.x, 32'd0);
        check("rst_y", bus.y, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases with hand-derived results
        do_tuple("centre", 32'd55660, 32'd33350, 16'd100, 32'd0, 32'd0, 1'b0, LAT_OK, 0);
        do_tuple("unit100", 32'd156170, 32'd109250, 16'd100, 32'd100, 32'd100, 1'b0, LAT_OK, 0);
        do_tuple("unit50", 32'd156170, 32'd109250, 16'd50, 32'd50, 32'd50, 1'b0, LAT_OK, 0);
        do_tuple("origin", 32'd0, 32'd0, 16'd1000, -32'sd553, -32'sd439, 1'b0, LAT_OK, 0);
        do_tuple("z_zero", 32'd156170, 32'd109250, 16'd0, 32'd0, 32'd0, 1'b1, 0, 3);
        do_tuple("z_neg5", 32'd156170, 32'd109250, -16'sd5, 32'd0, 32'd0, 1'b1, 0, 0);
        do_tuple("hold_valid", 32'd156170, 32'd109250, 16'd100, 32'd100, 32'd100, 1'b0, LAT_OK, 20);

        // Reset while the x division is running
        bus.in_valid = 1'b1;
        bus.u = 32'd156170;
        bus.v = 32'd109250;
        bus.z = 16'd77;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_x", bus.x, 32'd0);
        check("midrst_y", bus.y, 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_tuple("after_rst", 32'd0, 32'd0, 16'd1000, -32'sd553, -32'sd439, 1'b0, LAT_OK, 0);

        // Random tuples against the reference model
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                ru = 32'($urandom_range(0, 200000));
                rv = 32'($urandom_range(0, 200000));
            end else begin
                ru = $urandom;
                rv = $urandom;
            end
            if (k % 4 == 3) begin
                zi = -int'($urandom_range(0, 32768));
                rz = 16'(zi);
            end else begin
                rz = 16'($urandom_range(1, 32767));
            end
            if ($signed(rz) <= 0) begin
                do_tuple($sformatf("rand%0d", k), ru, rv, rz, 32'd0, 32'd0, 1'b1, 0, 0);
            end else begin
                ex = ref_coord(longint'($signed(ru)), longint'(CX * PIX_SCALE),
                               longint'($signed(rz)), longint'(FX * PIX_SCALE));
                ey = ref_coord(longint'($signed(rv)), longint'(CY * PIX_SCALE),
                               longint'($signed(rz)), longint'(FY * PIX_SCALE));
                do_tuple($sformatf("rand%0d", k), ru, rv, rz, ex, ey, 1'b0, LAT_OK,
                         (k == 5) ? 4 : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
